// File: rtl/func_unit_seq.sv
// func_unit_seq: multi-cycle two-operand unit with swap, add/sub, shift-add multiply and restoring divide.
module func_unit_seq #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             flag,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] rmode;
  logic [WIDTH-1:0] ra, rb, diff, x_nx, y_nx;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] sum, trial;
  logic fin, ge, flag_nx;
  assign busy = state == CALC;
  assign fin = busy && cnt == '0;
  assign sum = {1'b0, ra} + {1'b0, rb};
  // restoring-divide step: remainder lives in acc low half, quotient shifts into ra
  assign trial = {acc[WIDTH-1:0], ra[WIDTH-1]};
  assign ge = trial >= {1'b0, rb};
  assign diff = trial[WIDTH-1:0] - rb;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? CALC : IDLE) : (fin ? IDLE : CALC);
  end
  always_comb begin
    x_nx = rmode == 2'b00 ? rb : rmode == 2'b01 ? sum[WIDTH-1:0] : rmode == 2'b10 ? acc[WIDTH-1:0] : ra;
    y_nx = rmode == 2'b00 ? ra : rmode == 2'b01 ? ra - rb : rmode == 2'b10 ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    flag_nx = rmode == 2'b01 ? sum[WIDTH] : rmode == 2'b10 ? |acc[2*WIDTH-1:WIDTH] : rmode == 2'b11 ? rb == '0 : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rmode <= '0;
      ra <= '0;
      rb <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
      flag <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && start) begin
        ra <= a;
        rb <= b;
        rmode <= mode;
        acc <= '0;
        cnt <= mode[1] ? CW'(WIDTH) : '0;
      end else if (busy && !fin) begin
        cnt <= cnt - CW'(1);
        if (rmode == 2'b10) begin
          // MSB-first shift-add: acc = 2*acc + (multiplier bit ? multiplicand : 0)
          acc <= {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, (ra[WIDTH-1] ? rb : {WIDTH{1'b0}})};
          ra <= ra << 1;
        end else begin
          acc <= {{WIDTH{1'b0}}, (ge ? diff : trial[WIDTH-1:0])};
          ra <= {ra[WIDTH-2:0], ge};
        end
      end else if (fin) begin
        x <= x_nx;
        y <= y_nx;
        flag <= flag_nx;
      end
    end
  end
endmodule

// File: tb/tb_func_unit_seq.sv
// tb_func_unit_seq: directed and random checks of func_unit_seq against an arithmetic reference model.
module tb_func_unit_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [1:0] mode = '0;
  logic [W-1:0] a = '0, b = '0, x, y;
  logic flag, busy, done;
  int checks = 0, errors = 0;

  func_unit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .x(x), .y(y), .flag(flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output logic [W-1:0] ex, output logic [W-1:0] ey, output logic ef);
    int unsigned p;
    ex = '0; ey = '0; ef = 1'b0;
    case (m)
      2'd0: begin ex = bb; ey = aa; end
      2'd1: begin
        p = int'(aa) + int'(bb);
        ex = W'(p); ey = W'(int'(aa) - int'(bb) + (1 << W)); ef = p >= (1 << W);
      end
      2'd2: begin
        p = int'(aa) * int'(bb);
        ex = W'(p % (1 << W)); ey = W'(p / (1 << W)); ef = ey != 0;
      end
      default:
        if (bb == 0) begin ex = '1; ey = aa; ef = 1'b1; end
        else begin ex = aa / bb; ey = aa % bb; end
    endcase
  endtask

  task automatic run(input logic [1:0] m, input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
    logic [W-1:0] ex, ey;
    logic ef;
    int lat;
    model(m, aa, bb, ex, ey, ef);
    @(negedge clk);
    mode = m; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 2'($urandom);
    chk({tag, "_busy_on"}, busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, m[1] ? W + 1 : 1);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_flag"}, flag, ef);
    chk({tag, "_busy_off"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int dcnt, d1, d2;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    run(2'd0, 8'd220, 8'd125, "swap");
    run(2'd1, 8'd220, 8'd125, "add1");
    run(2'd1, 8'd10, 8'd20, "add2");
    run(2'd2, 8'd220, 8'd125, "mul1");
    run(2'd2, 8'd255, 8'd255, "mul_ones");
    run(2'd3, 8'd220, 8'd125, "div1");
    run(2'd3, 8'd220, 8'd0, "div_zero");
    run(2'd3, 8'd255, 8'd1, "div_by1");
    run(2'd3, 8'd7, 8'd200, "div_small");
    for (int m = 0; m < 4; m++) run(2'(m), 8'd0, 8'd0, "zero");
    for (int i = 0; i < 24; i++) run(2'($urandom), W'($urandom), W'($urandom), "rand");
    // start held for 20 edges: second request accepted only after the completion edge
    @(negedge clk);
    mode = 2'd2; a = 8'd220; b = 8'd125; start = 1'b1;
    dcnt = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (dcnt == 1) d1 = i; else d2 = i;
        chk("hold_x", x, 108); chk("hold_y", y, 107); chk("hold_flag", flag, 1);
      end
      a = i == 10 ? 8'd220 : W'($urandom);
      b = i == 10 ? 8'd125 : W'($urandom);
    end
    start = 1'b0;
    chk("hold_count", dcnt, 2); chk("hold_first", d1, 10); chk("hold_second", d2, 20);
    run(2'd0, 8'd220, 8'd125, "pre_rst");
    @(negedge clk);
    mode = 2'd2; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_x", x, 0); chk("abort_y", y, 0); chk("abort_flag", flag, 0);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run(2'd0, 8'd17, 8'd99, "post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
